gb_cpu_sequencer: RTL and testbench

M-cycle sequencer that consumes the per-instruction schedule produced by gb_cpu_decoder and drives the datapath one control word per M-cycle.
- Owns the instruction register, the 0xCB prefix state and the M-cycle step counter.
- Overlaps each instruction's final M-cycle with the next opcode fetch.
- Truncates conditional instructions whose condition is false.
- Hard-locks on illegal or empty schedules.
- Sits between the memory read bus and the decoder/datapath; one clk edge equals one M-cycle.

---
 rtl/gb_cpu_sequencer_pkg.sv | 63 ++++++
 rtl/gb_cpu_sequencer_if.sv | 32 +++
 rtl/gb_cpu_sequencer.sv | 114 +++++++++++
 tb/tb_gb_cpu_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_sequencer_pkg.sv
// ============================================================================
// gb_cpu_sequencer_pkg : control word, schedule and state types shared by the
// decoder, sequencer and datapath.                               rev 1.0
// ============================================================================
`default_nettype none

package gb_cpu_sequencer_pkg;

   localparam int SCHED_DEPTH = 6;

   typedef enum logic [1:0] {
      CC_NZ = 2'b00,
      CC_Z  = 2'b01,
      CC_NC = 2'b10,
      CC_C  = 2'b11
   } cond_code_t;

   // cond_check/cc are interpreted by the sequencer; the rest belongs to the datapath
   typedef struct packed {
      logic       cond_check;
      logic [1:0] cc;
      logic [1:0] addr_sel;
      logic       mem_rd;
      logic       mem_wr;
      logic       pc_inc;
      logic       ir_load;
      logic [3:0] alu_op;
      logic [2:0] reg_dst;
   } control_word_t;

   typedef struct packed {
      logic [2:0]                          num_cycles;
      control_word_t [0:SCHED_DEPTH-1]     mcycles;
   } schedule_t;

   localparam control_word_t FETCH_CTRL = '{
      cond_check: 1'b0, cc: 2'b00, addr_sel: 2'b00, mem_rd: 1'b1, mem_wr: 1'b0,
      pc_inc: 1'b1, ir_load: 1'b1, alu_op: 4'h0, reg_dst: 3'h0
   };

   localparam control_word_t NOP_CTRL = '0;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      EXEC   = 2'd1,
      LOCKED = 2'd2
   } seq_state_t;

   // flags are {Z,N,H,C}
   function automatic logic condMet(input logic [1:0] cc, input logic [3:0] flags);
      logic met;
      case (cond_code_t'(cc))
         CC_NZ:   met = ~flags[3];
         CC_Z:    met =  flags[3];
         CC_NC:   met = ~flags[0];
         default: met =  flags[0];
      endcase
      return met;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gb_cpu_sequencer_if.sv
// ============================================================================
// gb_cpu_sequencer_if : decoder/bus/datapath signals around the sequencer.
//                                                                rev 1.0
// ============================================================================
`default_nettype none

interface gb_cpu_sequencer_if;
   import gb_cpu_sequencer_pkg::*;

   schedule_t     schedule;
   logic [7:0]    bus_rdata;
   logic [3:0]    flags;
   logic [7:0]    opcode;
   logic          cb_prefix;
   control_word_t ctrl;
   logic [2:0]    mcycle;
   logic          instr_start;
   logic          locked;

   modport master (
      input  schedule, bus_rdata, flags,
      output opcode, cb_prefix, ctrl, mcycle, instr_start, locked
   );

   modport slave (
      output schedule, bus_rdata, flags,
      input  opcode, cb_prefix, ctrl, mcycle, instr_start, locked
   );

endinterface

`default_nettype wire

// File: rtl/gb_cpu_sequencer.sv
// ============================================================================
// gb_cpu_sequencer : M-cycle sequencer, one control word per clk edge, with
// fetch overlap, conditional truncation and hard lock.            rev 1.0
// ============================================================================
`default_nettype none

module gb_cpu_sequencer
   import gb_cpu_sequencer_pkg::*;
#(
   parameter int MAX_MCYCLES = 6
) (
   input  wire logic             clk,
   input  wire logic             reset,
   gb_cpu_sequencer_if.master    cpu_io
);

   localparam logic [2:0] c_max_num = 3'(MAX_MCYCLES);

   seq_state_t    state_q, state_d;
   logic [7:0]    opcode_q, opcode_d;
   logic          cb_q, cb_d;
   logic [2:0]    step_q, step_d;
   logic          abort_q, abort_d;

   control_word_t ctrl_c;
   control_word_t sched_word_c;
   logic          instr_start_c;
   logic          locked_c;
   logic          last_c;
   logic          illegal_c;
   logic [2:0]    num_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= BOOT;
         opcode_q <= 8'h00;
         cb_q     <= 1'b0;
         step_q   <= 3'd0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         cb_q     <= cb_d;
         step_q   <= step_d;
         abort_q  <= abort_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      cb_d          = cb_q;
      step_d        = step_q;
      abort_d       = abort_q;
      ctrl_c        = NOP_CTRL;
      instr_start_c = 1'b0;
      locked_c      = 1'b0;
      num_c         = cpu_io.schedule.num_cycles;
      sched_word_c  = cpu_io.schedule.mcycles[step_q];
      last_c        = 1'b0;
      illegal_c     = 1'b0;

      case (state_q)
         BOOT: begin
            ctrl_c   = FETCH_CTRL;
            opcode_d = cpu_io.bus_rdata;
            cb_d     = 1'b0;
            step_d   = 3'd0;
            state_d  = EXEC;
         end

         EXEC: begin
            instr_start_c = (step_q == 3'd0);
            illegal_c     = (step_q == 3'd0) && ((num_c == 3'd0) || (num_c > c_max_num));
            last_c        = (step_q == (num_c - 3'd1)) || abort_q;
            if (illegal_c) begin
               state_d = LOCKED;
            end else begin
               // an aborted instruction spends its remaining cycle fetching the next opcode
               ctrl_c = abort_q ? FETCH_CTRL : sched_word_c;
               if (last_c) begin
                  opcode_d = cpu_io.bus_rdata;
                  step_d   = 3'd0;
                  abort_d  = 1'b0;
                  cb_d     = (opcode_q == 8'hCB) && !cb_q;
               end else begin
                  step_d = step_q + 3'd1;
                  if (sched_word_c.cond_check && !condMet(sched_word_c.cc, cpu_io.flags)) begin
                     abort_d = 1'b1;
                  end
               end
            end
         end

         LOCKED: begin
            locked_c = 1'b1;
         end

         default: begin
            state_d = LOCKED;
         end
      endcase
   end

   assign cpu_io.opcode      = opcode_q;
   assign cpu_io.cb_prefix   = cb_q;
   assign cpu_io.ctrl        = ctrl_c;
   assign cpu_io.mcycle      = step_q;
   assign cpu_io.instr_start = instr_start_c;
   assign cpu_io.locked      = locked_c;

endmodule

`default_nettype wire

// File: tb/tb_gb_cpu_sequencer.sv
// ============================================================================
// tb_gb_cpu_sequencer : directed scenarios plus random instruction streams
// against an instruction-level model.                            rev 1.0
// ============================================================================
`default_nettype none

module tb_gb_cpu_sequencer;
   import gb_cpu_sequencer_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   gb_cpu_sequencer_if sif();

   gb_cpu_sequencer #(.MAX_MCYCLES(6)) dut (
      .clk    (clk),
      .reset  (reset),
      .cpu_io (sif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic          exp_valid = 1'b0;
   logic [7:0]    e_op;
   logic          e_cb;
   control_word_t e_ctrl;
   logic [2:0]    e_mc;
   logic          e_is;
   logic          e_lk;

   schedule_t rom [512];

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      cmp("opcode",      {24'h0, sif.opcode},      {24'h0, e_op});
      cmp("cb_prefix",   {31'h0, sif.cb_prefix},   {31'h0, e_cb});
      cmp("ctrl",        {16'h0, sif.ctrl},        {16'h0, e_ctrl});
      cmp("mcycle",      {29'h0, sif.mcycle},      {29'h0, e_mc});
      cmp("instr_start", {31'h0, sif.instr_start}, {31'h0, e_is});
      cmp("locked",      {31'h0, sif.locked},      {31'h0, e_lk});
   endtask

   always @(negedge clk) begin
      if (exp_valid) check_all();
   end

   task automatic boot_exp();
      e_op = 8'h00; e_cb = 1'b0; e_ctrl = FETCH_CTRL; e_mc = 3'd0; e_is = 1'b0; e_lk = 1'b0;
   endtask

   // drive one M-cycle, publish what the outputs must be, advance one edge
   task automatic cyc(input schedule_t s, input logic [3:0] f, input logic [7:0] b,
                      input logic [7:0] op, input logic cb, input control_word_t c,
                      input logic [2:0] mc, input logic is, input logic lk);
      sif.schedule  = s;
      sif.flags     = f;
      sif.bus_rdata = b;
      e_op = op; e_cb = cb; e_ctrl = c; e_mc = mc; e_is = is; e_lk = lk;
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond_ok(input logic [1:0] cc, input logic [3:0] f);
      bit z, c;
      z = f[3];
      c = f[0];
      if (cc == 2'b00) return !z;
      if (cc == 2'b01) return z;
      if (cc == 2'b10) return !c;
      return c;
   endfunction

   function automatic control_word_t rnd_word();
      control_word_t w;
      w = control_word_t'(16'($urandom));
      w.cond_check = ($urandom_range(0, 2) == 0);
      return w;
   endfunction

   function automatic logic [7:0] rnd_byte();
      return ($urandom_range(0, 5) == 0) ? 8'hCB : 8'($urandom);
   endfunction

   initial begin
      schedule_t     fetch1, s2, s3, s0, s6, s;
      control_word_t wa, w0, w1, ec;
      logic [7:0]    m_op, b, last_b, prev_op;
      logic          m_cb;
      logic [3:0]    f [6];
      int            n, len;
      bit            ab, found;

      wa = control_word_t'(16'h0A41);
      w0 = control_word_t'(16'hA012);   // cond_check=1, cc=Z
      w1 = control_word_t'(16'h0123);

      fetch1 = '0; fetch1.num_cycles = 3'd1; fetch1.mcycles[0] = FETCH_CTRL;
      s2 = '0; s2.num_cycles = 3'd2; s2.mcycles[0] = wa; s2.mcycles[1] = FETCH_CTRL;
      s3 = '0; s3.num_cycles = 3'd3; s3.mcycles[0] = w0; s3.mcycles[1] = w1; s3.mcycles[2] = FETCH_CTRL;
      s0 = '0; s0.num_cycles = 3'd0; s0.mcycles[0] = w1;
      s6 = '0; s6.num_cycles = 3'd6;
      for (int k = 0; k < 6; k++) begin
         s6.mcycles[k] = rnd_word();
         s6.mcycles[k].cond_check = 1'b0;
      end
      s6.mcycles[3] = control_word_t'(16'h1234);
      s6.mcycles[5] = FETCH_CTRL;

      for (int i = 0; i < 512; i++) begin
         rom[i] = '0;
         n = $urandom_range(1, 6);
         rom[i].num_cycles = 3'(n);
         for (int k = 0; k < 6; k++) rom[i].mcycles[k] = rnd_word();
         rom[i].mcycles[n-1] = FETCH_CTRL;
         rom[i].mcycles[n-1].cond_check = ($urandom_range(0, 1) == 0);
      end
      rom[{1'b0, 8'hCB}] = fetch1;

      sif.schedule = fetch1; sif.bus_rdata = 8'h3C; sif.flags = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      boot_exp();
      check_all();
      reset = 1'b0;

      // boot fetch, then a 1-cycle instruction
      cyc(fetch1, 4'h0, 8'h3C, 8'h00, 1'b0, FETCH_CTRL, 3'd0, 1'b0, 1'b0);
      cyc(fetch1, 4'h0, 8'hC6, 8'h3C, 1'b0, FETCH_CTRL, 3'd0, 1'b1, 1'b0);
      // 2-cycle instruction
      cyc(s2, 4'h0, 8'h00, 8'hC6, 1'b0, wa,         3'd0, 1'b1, 1'b0);
      cyc(s2, 4'h0, 8'hCB, 8'hC6, 1'b0, FETCH_CTRL, 3'd1, 1'b0, 1'b0);
      // CB prefix then prefixed opcode
      cyc(fetch1, 4'h0, 8'h37, 8'hCB, 1'b0, FETCH_CTRL, 3'd0, 1'b1, 1'b0);
      cyc(fetch1, 4'h0, 8'h00, 8'h37, 1'b1, FETCH_CTRL, 3'd0, 1'b1, 1'b0);
      // condition Z false: truncated after two cycles
      cyc(s3, 4'b0000, 8'h55, 8'h00, 1'b0, w0,         3'd0, 1'b1, 1'b0);
      cyc(s3, 4'b0000, 8'h20, 8'h00, 1'b0, FETCH_CTRL, 3'd1, 1'b0, 1'b0);
      // condition Z true: full schedule
      cyc(s3, 4'b1000, 8'h55, 8'h20, 1'b0, w0,         3'd0, 1'b1, 1'b0);
      cyc(s3, 4'b1000, 8'h55, 8'h20, 1'b0, w1,         3'd1, 1'b0, 1'b0);
      cyc(s3, 4'b1000, 8'h28, 8'h20, 1'b0, FETCH_CTRL, 3'd2, 1'b0, 1'b0);
      // empty schedule locks
      cyc(s0, 4'h0, 8'h99, 8'h28, 1'b0, NOP_CTRL, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++)
         cyc(s6, 4'($urandom), 8'($urandom), 8'h28, 1'b0, NOP_CTRL, 3'd0, 1'b0, 1'b1);

      exp_valid = 1'b0;
      reset = 1'b1;
      #1;
      boot_exp();
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // reset in the middle of a 6-cycle instruction
      cyc(fetch1, 4'h0, 8'h11, 8'h00, 1'b0, FETCH_CTRL, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         cyc(s6, 4'h0, 8'hEE, 8'h11, 1'b0, s6.mcycles[k], 3'(k), (k == 0), 1'b0);
      sif.schedule = s6;
      e_op = 8'h11; e_cb = 1'b0; e_ctrl = s6.mcycles[3]; e_mc = 3'd3; e_is = 1'b0; e_lk = 1'b0;
      exp_valid = 1'b1;
      @(negedge clk);
      #2;
      exp_valid = 1'b0;
      reset = 1'b1;
      #1;
      boot_exp();
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // random instruction stream
      b = rnd_byte();
      cyc(fetch1, 4'h0, b, 8'h00, 1'b0, FETCH_CTRL, 3'd0, 1'b0, 1'b0);
      m_op = b;
      m_cb = 1'b0;
      for (int i = 0; i < 400; i++) begin
         s = rom[{m_cb, m_op}];
         n = int'(s.num_cycles);
         for (int k = 0; k < 6; k++) f[k] = 4'($urandom);
         len = n;
         ab = 1'b0;
         found = 1'b0;
         for (int k = 0; k < n - 1; k++) begin
            if (!found && s.mcycles[k].cond_check && !cond_ok(s.mcycles[k].cc, f[k])) begin
               len = k + 2;
               ab = 1'b1;
               found = 1'b1;
            end
         end
         last_b = 8'h00;
         for (int k = 0; k < len; k++) begin
            b = rnd_byte();
            ec = (ab && k == len - 1) ? FETCH_CTRL : s.mcycles[k];
            cyc(s, f[k], b, m_op, m_cb, ec, 3'(k), (k == 0), 1'b0);
            last_b = b;
         end
         prev_op = m_op;
         m_op = last_b;
         m_cb = (prev_op == 8'hCB) && !m_cb;
      end

      exp_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
